// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle between the PC sequencer and decode/control.
// The master side is the sequencer; the slave side is decode/imem.
interface fetch_if #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             stall;
    logic             branch_taken;
    logic [PC_W-1:0]  branch_target;
    logic             halt;
    logic [PC_W-1:0]  pc;
    logic             fetch_valid;
    logic             done;
    logic             pc_wrap;
    logic [CNT_W-1:0] retired;

    modport master (
        input  start, stall, branch_taken, branch_target, halt,
        output pc, fetch_valid, done, pc_wrap, retired
    );

    modport slave (
        output start, stall, branch_taken, branch_target, halt,
        input  pc, fetch_valid, done, pc_wrap, retired
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and fetch sequencer with a saturating retire count.
// Three-state FSM: IDLE -> RUN -> HALTED, restartable with start.
module fetch_sequencer #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned CNT_W      = 16
) (
    input logic clk,
    input logic reset,
    fetch_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] ret_inc;

    assign ret_inc = (ret_q == '1) ? ret_q : ret_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ret_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ret_q   <= ret_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ret_d   = ret_q;
        wrap_d  = wrap_q;
        unique case (state_q)
            IDLE, HALTED: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = PC_W'(START_ADDR);
                    ret_d   = '0;
                    wrap_d  = 1'b0;
                end
            end
            RUN: begin
                // stall > halt > branch > sequential
                if (bus.stall) begin
                    state_d = RUN;
                end else if (bus.halt) begin
                    state_d = HALTED;
                    ret_d   = ret_inc;
                end else if (bus.branch_taken) begin
                    pc_d  = bus.branch_target;
                    ret_d = ret_inc;
                end else begin
                    pc_d  = pc_q + 1'b1;
                    ret_d = ret_inc;
                    if (pc_q == '1) begin
                        wrap_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.fetch_valid = (state_q == RUN);
    assign bus.done        = (state_q == HALTED);
    assign bus.pc_wrap     = wrap_q;
    assign bus.retired     = ret_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench: directed steps push expectations, a monitor checks.
// A second instance with a 3-bit counter exercises saturation.
module tb_fetch_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       br = 1'b0;
    logic [9:0] tgt = '0;
    logic       halt = 1'b0;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [9:0]  pc;
        logic        fv;
        logic        done;
        logic        wrap;
        logic [15:0] ret;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    fetch_if #(.PC_W(10), .CNT_W(16)) b16 ();
    fetch_if #(.PC_W(10), .CNT_W(3))  b3 ();

    assign b16.start         = start;
    assign b16.stall         = stall;
    assign b16.branch_taken  = br;
    assign b16.branch_target = tgt;
    assign b16.halt          = halt;
    assign b3.start          = start;
    assign b3.stall          = stall;
    assign b3.branch_taken   = br;
    assign b3.branch_target  = tgt;
    assign b3.halt           = halt;

    fetch_sequencer #(.PC_W(10), .START_ADDR(0), .CNT_W(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (b16.master)
    );

    fetch_sequencer #(.PC_W(10), .START_ADDR(0), .CNT_W(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b3.master)
    );

    always @(posedge clk) begin
        exp_t       e;
        logic [2:0] r3;
        #1;
        if (q.size() > 0) begin
            e  = q.pop_front();
            r3 = (e.ret > 16'd7) ? 3'd7 : e.ret[2:0];
            checks++;
            if (b16.pc !== e.pc || b16.fetch_valid !== e.fv ||
                b16.done !== e.done || b16.pc_wrap !== e.wrap ||
                b16.retired !== e.ret || b3.pc !== e.pc ||
                b3.fetch_valid !== e.fv || b3.done !== e.done ||
                b3.pc_wrap !== e.wrap || b3.retired !== r3) begin
                $display("FAIL step%0d: got pc=%h fv=%b done=%b wrap=%b ret=%0d ret3=%0d, want pc=%h fv=%b done=%b wrap=%b ret=%0d ret3=%0d",
                         checks, b16.pc, b16.fetch_valid, b16.done,
                         b16.pc_wrap, b16.retired, b3.retired,
                         e.pc, e.fv, e.done, e.wrap, e.ret, r3);
            end else begin
                passed++;
            end
        end
    end

    task automatic step(
        input logic        st, stl, b, hl,
        input logic [9:0]  t,
        input logic [9:0]  epc,
        input logic        efv, ed, ew,
        input logic [15:0] er
    );
        exp_t e;
        @(negedge clk);
        start = st;
        stall = stl;
        br    = b;
        halt  = hl;
        tgt   = t;
        e.pc   = epc;
        e.fv   = efv;
        e.done = ed;
        e.wrap = ew;
        e.ret  = er;
        q.push_back(e);
    endtask

    task automatic chk_zero(input string nm);
        checks++;
        if (b16.pc !== '0 || b16.fetch_valid !== 1'b0 ||
            b16.done !== 1'b0 || b16.pc_wrap !== 1'b0 ||
            b16.retired !== '0 || b3.pc !== '0 ||
            b3.fetch_valid !== 1'b0 || b3.retired !== '0) begin
            $display("FAIL %s: got pc=%h fv=%b done=%b wrap=%b ret=%0d, want all zero",
                     nm, b16.pc, b16.fetch_valid, b16.done,
                     b16.pc_wrap, b16.retired);
        end else begin
            passed++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_zero("reset_hold");
        reset = 1'b1;

        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 0, 10'h0, 10'h0, 0, 0, 0, 0);

        // straight-line then halt at pc=4
        step(1, 0, 0, 0, 10'h0, 10'h0, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++)
            step(0, 0, 0, 0, 10'h0, 10'(i), 1, 0, 0, 16'(i));
        step(0, 0, 0, 1, 10'h0, 10'h4, 0, 1, 0, 5);
        step(0, 1, 0, 0, 10'h0, 10'h4, 0, 1, 0, 5);
        step(0, 0, 1, 0, 10'h2A, 10'h4, 0, 1, 0, 5);

        // branch, stall, halt+branch
        step(1, 0, 0, 0, 10'h0, 10'h0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 10'h0, 10'h1, 1, 0, 0, 1);
        step(0, 0, 0, 0, 10'h0, 10'h2, 1, 0, 0, 2);
        step(0, 0, 1, 0, 10'h3F0, 10'h3F0, 1, 0, 0, 3);
        step(0, 1, 0, 0, 10'h0, 10'h3F0, 1, 0, 0, 3);
        step(0, 1, 1, 0, 10'h10, 10'h3F0, 1, 0, 0, 3);
        step(0, 1, 0, 1, 10'h0, 10'h3F0, 1, 0, 0, 3);
        step(0, 0, 1, 1, 10'h100, 10'h3F0, 0, 1, 0, 4);

        // start+halt in HALTED: start acts
        step(1, 0, 0, 1, 10'h0, 10'h0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 10'h3FE, 10'h3FE, 1, 0, 0, 1);
        step(0, 0, 0, 0, 10'h0, 10'h3FF, 1, 0, 0, 2);
        step(0, 0, 0, 0, 10'h0, 10'h000, 1, 0, 1, 3);
        step(0, 0, 0, 0, 10'h0, 10'h001, 1, 0, 1, 4);
        step(1, 0, 0, 0, 10'h0, 10'h002, 1, 0, 1, 5);
        step(1, 0, 0, 1, 10'h0, 10'h002, 0, 1, 1, 6);
        step(1, 0, 0, 0, 10'h0, 10'h000, 1, 0, 0, 0);

        for (int i = 1; i <= 7; i++)
            step(0, 0, 0, 0, 10'h0, 10'(i), 1, 0, 0, 16'(i));

        // asynchronous reset between edges at pc=7
        @(negedge clk);
        start = 0;
        #1 reset = 1'b0;
        #1 chk_zero("async_reset");
        @(negedge clk);
        chk_zero("reset_across_edge");
        reset = 1'b1;

        // saturation: 10 instructions then halt, then restart
        step(1, 0, 0, 0, 10'h0, 10'h0, 1, 0, 0, 0);
        for (int i = 1; i <= 10; i++)
            step(0, 0, 0, 0, 10'h0, 10'(i), 1, 0, 0, 16'(i));
        step(0, 0, 0, 1, 10'h0, 10'd10, 0, 1, 0, 11);
        step(1, 0, 0, 0, 10'h0, 10'h0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 10'h0, 10'h1, 1, 0, 0, 1);

        @(negedge clk);
        start = 0;
        stall = 0;
        br    = 0;
        halt  = 0;
        for (int i = 0; i < 5 && q.size() > 0; i++)
            @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
